// File: rtl/spi_flash.sv
// -----------------------------------------------------------------------------
// spi_flash
//   Read-only SPI NOR flash emulator. Decodes single-lane READ transactions
//   (opcode, 24-bit address, then streamed data) arriving on csb/spiclk/io0
//   and serves the bytes from a synchronous BRAM port, MSB-first on io1.
//   Bytes are picked out of each 32-bit BRAM word little-endian. The next
//   word is prefetched into a second buffer while the last byte of the
//   current word is shifting out, so a stream never stalls.
//
// Ports
//   ap_clk, ap_rst      system clock, asynchronous active-high reset
//   romcode_*           BRAM port A (read only: WEN/Din tied low)
//   csb, spiclk, io0    SPI chip select (active low), clock (mode 0), MOSI
//   io1                 MISO, changes only on spiclk falling edges
//
// Handshake: the BRAM port has no valid/ready pair. Each romcode_EN_A pulse
//   is one fetch; romcode_Dout_A holds that word one ap_clk later, and it is
//   captured exactly then. A fetch in flight when csb rises is dropped.
// -----------------------------------------------------------------------------
module spi_flash #(
    parameter int          ADDR_BITS = 24,
    parameter logic [7:0]  READ_CMD  = 8'h03
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    output logic [31:0] romcode_Addr_A,
    output logic        romcode_EN_A,
    output logic [3:0]  romcode_WEN_A,
    output logic [31:0] romcode_Din_A,
    input  logic [31:0] romcode_Dout_A,
    output logic        romcode_Clk_A,
    output logic        romcode_Rst_A,
    input  logic        csb,
    input  logic        spiclk,
    input  logic        io0,
    output logic        io1
);

    localparam int AW = ADDR_BITS;
    localparam int CW = $clog2(AW + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            csb_q, csb_d, csb_p_q, csb_p_d;
    logic            sclk_q, sclk_d, sclk_p_q, sclk_p_d;
    logic            io0_q, io0_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [AW-2:0]   shift_q, shift_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     buf_q, buf_d;
    logic [31:0]     nbuf_q, nbuf_d;
    logic            en_q, en_d;
    logic [31:0]     rom_addr_q, rom_addr_d;
    logic            fetch_nbuf_q, fetch_nbuf_d;  // current fetch targets nbuf
    logic            cap_q, cap_d;                // Dout_A is valid this cycle
    logic            cap_nbuf_q, cap_nbuf_d;
    logic            first_q, first_d;            // no data bit driven yet
    logic [2:0]      bit_idx_q, bit_idx_d;        // bit currently on io1
    logic            io1_q, io1_d;

    logic            sclk_rise, sclk_fall, csb_fall;
    logic [AW-1:0]   drv_addr, nxt_addr, pf_addr;
    logic [31:0]     drv_word;
    logic [7:0]      drv_byte, cur_byte;
    logic            start_byte;

    assign sclk_rise = sclk_q & ~sclk_p_q;
    assign sclk_fall = ~sclk_q & sclk_p_q;
    assign csb_fall  = ~csb_q & csb_p_q;

    always_comb begin
        state_d      = state_q;
        csb_d        = csb;
        csb_p_d      = csb_q;
        sclk_d       = spiclk;
        sclk_p_d     = sclk_q;
        io0_d        = io0;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        buf_d        = buf_q;
        nbuf_d       = nbuf_q;
        en_d         = 1'b0;
        rom_addr_d   = rom_addr_q;
        fetch_nbuf_d = fetch_nbuf_q;
        cap_d        = en_q;
        cap_nbuf_d   = fetch_nbuf_q;
        first_d      = first_q;
        bit_idx_d    = bit_idx_q;
        io1_d        = io1_q;
        drv_addr     = addr_q;
        drv_word     = buf_q;
        nxt_addr     = addr_q + 1'b1;
        pf_addr      = '0;
        drv_byte     = '0;
        cur_byte     = buf_q[{addr_q[1:0], 3'b000} +: 8];
        start_byte   = 1'b0;

        if (cap_q && !csb_q) begin
            if (cap_nbuf_q) nbuf_d = romcode_Dout_A;
            else            buf_d  = romcode_Dout_A;
        end

        // csb high overrides everything, including a same-cycle spiclk edge.
        if (csb_q) begin
            state_d   = IDLE;
            io1_d     = 1'b0;
            en_d      = 1'b0;
            cap_d     = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csb_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_d   = {shift_q[AW-3:0], io0_q};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CW'(7)) begin
                            bit_cnt_d = '0;
                            state_d   = ({shift_q[6:0], io0_q} == READ_CMD) ? ADDR : IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        shift_d   = {shift_q[AW-3:0], io0_q};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CW'(AW - 1)) begin
                            addr_d       = {shift_q, io0_q};
                            en_d         = 1'b1;
                            fetch_nbuf_d = 1'b0;
                            rom_addr_d   = 32'({shift_q[AW-2:1], 2'b00});
                            first_d      = 1'b1;
                            state_d      = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        if (first_q) begin
                            first_d    = 1'b0;
                            start_byte = 1'b1;
                        end else if (bit_idx_q != 3'd0) begin
                            bit_idx_d = bit_idx_q - 3'd1;
                            io1_d     = cur_byte[bit_idx_q - 3'd1];
                        end else begin
                            // Byte boundary: advance address, swap in the
                            // prefetched word when crossing a word boundary.
                            addr_d     = nxt_addr;
                            drv_addr   = nxt_addr;
                            start_byte = 1'b1;
                            if (addr_q[1:0] == 2'd3) begin
                                buf_d    = nbuf_q;
                                drv_word = nbuf_q;
                            end
                        end
                        if (start_byte) begin
                            drv_byte  = drv_word[{drv_addr[1:0], 3'b000} +: 8];
                            io1_d     = drv_byte[7];
                            bit_idx_d = 3'd7;
                            if (drv_addr[1:0] == 2'd3) begin
                                pf_addr      = drv_addr + 1'b1;
                                en_d         = 1'b1;
                                fetch_nbuf_d = 1'b1;
                                rom_addr_d   = 32'({pf_addr[AW-1:2], 2'b00});
                            end
                        end
                    end
                end
                IGNORE: begin
                    io1_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            csb_q        <= 1'b1;
            csb_p_q      <= 1'b1;
            sclk_q       <= 1'b0;
            sclk_p_q     <= 1'b0;
            io0_q        <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            buf_q        <= '0;
            nbuf_q       <= '0;
            en_q         <= 1'b0;
            rom_addr_q   <= '0;
            fetch_nbuf_q <= 1'b0;
            cap_q        <= 1'b0;
            cap_nbuf_q   <= 1'b0;
            first_q      <= 1'b0;
            bit_idx_q    <= '0;
            io1_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            csb_q        <= csb_d;
            csb_p_q      <= csb_p_d;
            sclk_q       <= sclk_d;
            sclk_p_q     <= sclk_p_d;
            io0_q        <= io0_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            buf_q        <= buf_d;
            nbuf_q       <= nbuf_d;
            en_q         <= en_d;
            rom_addr_q   <= rom_addr_d;
            fetch_nbuf_q <= fetch_nbuf_d;
            cap_q        <= cap_d;
            cap_nbuf_q   <= cap_nbuf_d;
            first_q      <= first_d;
            bit_idx_q    <= bit_idx_d;
            io1_q        <= io1_d;
        end
    end

    assign romcode_Addr_A = rom_addr_q;
    assign romcode_EN_A   = en_q;
    assign romcode_WEN_A  = '0;
    assign romcode_Din_A  = '0;
    assign romcode_Clk_A  = ap_clk;
    assign romcode_Rst_A  = ap_rst;
    assign io1            = io1_q;

endmodule

// File: tb/tb_spi_flash.sv
// -----------------------------------------------------------------------------
// tb_spi_flash
//   Directed bench for spi_flash: a mode-0 SPI master built from tasks, a
//   behavioural synchronous BRAM holding a few known words, and a monitor
//   logging every BRAM fetch. Each scenario task checks its own results.
// -----------------------------------------------------------------------------
module tb_spi_flash;

  localparam int HALF = 6;  // spiclk half period in ap_clk cycles

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [31:0] romcode_Addr_A;
  logic        romcode_EN_A;
  logic [3:0]  romcode_WEN_A;
  logic [31:0] romcode_Din_A;
  logic [31:0] romcode_Dout_A = 32'h0;
  logic        romcode_Clk_A;
  logic        romcode_Rst_A;
  logic        csb = 1'b1;
  logic        spiclk = 1'b0;
  logic        io0 = 1'b0;
  logic        io1;

  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  logic [31:0] en_addr[$];

  spi_flash dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .romcode_Addr_A (romcode_Addr_A),
    .romcode_EN_A   (romcode_EN_A),
    .romcode_WEN_A  (romcode_WEN_A),
    .romcode_Din_A  (romcode_Din_A),
    .romcode_Dout_A (romcode_Dout_A),
    .romcode_Clk_A  (romcode_Clk_A),
    .romcode_Rst_A  (romcode_Rst_A),
    .csb            (csb),
    .spiclk         (spiclk),
    .io0            (io0),
    .io1            (io1)
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  // ---------------- BRAM model and fetch monitor ----------------
  function automatic logic [31:0] rom_word(input logic [21:0] w);
    case (w)
      22'h000000: return 32'h44332211;
      22'h000001: return 32'h88776655;
      22'h3FFFFF: return 32'hDDCCBBAA;
      default:    return 32'h0BADF00D;
    endcase
  endfunction

  always @(posedge ap_clk) begin
    if (romcode_EN_A) romcode_Dout_A <= rom_word(romcode_Addr_A[23:2]);
  end

  always @(negedge ap_clk) begin
    if (romcode_EN_A === 1'b1) begin
      en_cnt = en_cnt + 1;
      en_addr.push_back(romcode_Addr_A);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic clear_log();
    en_cnt = 0;
    en_addr.delete();
  endtask

  task automatic spi_begin();
    spiclk = 1'b0;
    csb    = 1'b0;
    wait_cyc(4);
  endtask

  task automatic spi_end();
    spiclk = 1'b0;
    wait_cyc(2);
    csb = 1'b1;
    wait_cyc(4);
  endtask

  // Master: set MOSI while low, sample MISO just before the rise.
  task automatic spi_bit(input logic b, output logic r);
    io0 = b;
    wait_cyc(HALF);
    r = io1;
    spiclk = 1'b1;
    wait_cyc(HALF);
    spiclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic send_read(input logic [23:0] a);
    logic [7:0] dummy;
    spi_byte(8'h03, dummy);
    spi_byte(a[23:16], dummy);
    spi_byte(a[15:8], dummy);
    spi_byte(a[7:0], dummy);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ap_rst = 1'b1;
    wait_cyc(3);
    checks++; if (io1 !== 1'b0) begin errors++; $display("FAIL reset_io1 got %b exp 0", io1); end
    checks++; if (romcode_EN_A !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", romcode_EN_A); end
    checks++; if (romcode_Addr_A !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", romcode_Addr_A); end
    checks++; if (romcode_Rst_A !== 1'b1) begin errors++; $display("FAIL reset_rst_a got %b exp 1", romcode_Rst_A); end
    ap_rst = 1'b0;
    wait_cyc(3);
    checks++; if (romcode_WEN_A !== 4'h0 || romcode_Din_A !== 32'h0) begin
      errors++; $display("FAIL tie_off got wen=%h din=%h exp 0/0", romcode_WEN_A, romcode_Din_A);
    end
    checks++; if (romcode_Rst_A !== 1'b0 || romcode_Clk_A !== ap_clk) begin
      errors++; $display("FAIL bram_clk_rst got rst=%b clk=%b exp 0/%b", romcode_Rst_A, romcode_Clk_A, ap_clk);
    end
  endtask

  task automatic test_read_word0();
    logic [7:0] rx;
    logic [7:0] exp_b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    spi_begin();
    send_read(24'h000000);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== exp_b[i]) begin errors++; $display("FAIL word0_byte%0d got %h exp %h", i, rx, exp_b[i]); end
      if (i == 0) begin
        checks++; if (en_cnt != 1 || en_addr[0] !== 32'h0) begin
          errors++; $display("FAIL word0_fetch got cnt=%0d addr=%h exp 1/0", en_cnt, (en_addr.size() > 0) ? en_addr[0] : 32'hX);
        end
      end
    end
    spi_end();
  endtask

  task automatic test_read_offset2();
    logic [7:0] rx;
    logic [7:0] exp_b[4] = '{8'h33, 8'h44, 8'h55, 8'h66};
    clear_log();
    spi_begin();
    send_read(24'h000002);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== exp_b[i]) begin errors++; $display("FAIL off2_byte%0d got %h exp %h", i, rx, exp_b[i]); end
      if (i == 1) begin
        checks++; if (en_cnt != 2 || en_addr[1] !== 32'h4) begin
          errors++; $display("FAIL off2_prefetch got cnt=%0d addr=%h exp 2/4", en_cnt, (en_addr.size() > 1) ? en_addr[1] : 32'hX);
        end
      end
    end
    spi_end();
  endtask

  task automatic test_bad_opcode();
    logic [7:0] rx;
    logic [7:0] acc;
    clear_log();
    acc = 8'h00;
    spi_begin();
    spi_byte(8'hAB, rx);
    acc = acc | rx;
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'hFF, rx);
      acc = acc | rx;
    end
    spi_end();
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL bad_op_io1 got %h exp 00", acc); end
    checks++; if (en_cnt != 0) begin errors++; $display("FAIL bad_op_fetch got %0d exp 0", en_cnt); end
    spi_begin();
    send_read(24'h000000);
    spi_byte(8'h00, rx);
    spi_end();
    checks++; if (rx !== 8'h11) begin errors++; $display("FAIL bad_op_recover got %h exp 11", rx); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic       r;
    logic [7:0] exp_b[4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    clear_log();
    spi_begin();
    spi_byte(8'h03, rx);
    for (int i = 0; i < 10; i++) spi_bit(1'b1, r);
    spi_end();
    checks++; if (en_cnt != 0) begin errors++; $display("FAIL abort_fetch got %0d exp 0", en_cnt); end
    spi_begin();
    send_read(24'h000004);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== exp_b[i]) begin errors++; $display("FAIL abort_byte%0d got %h exp %h", i, rx, exp_b[i]); end
    end
    spi_end();
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    clear_log();
    spi_begin();
    send_read(24'hFFFFFF);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'hDD) begin errors++; $display("FAIL wrap_byte0 got %h exp dd", rx); end
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h11) begin errors++; $display("FAIL wrap_byte1 got %h exp 11", rx); end
    spi_end();
    checks++; if (en_cnt != 2 || en_addr[0] !== 32'h00FFFFFC || en_addr[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_fetch got cnt=%0d a0=%h a1=%h exp 2/00fffffc/0", en_cnt,
                         (en_addr.size() > 0) ? en_addr[0] : 32'hX, (en_addr.size() > 1) ? en_addr[1] : 32'hX);
    end
  endtask

  task automatic test_reset_in_data();
    logic [7:0] rx;
    clear_log();
    spi_begin();
    send_read(24'hFFFFFC);
    wait_cyc(5);
    checks++; if (io1 !== 1'b1) begin errors++; $display("FAIL rst_data_pre got %b exp 1", io1); end
    ap_rst = 1'b1;
    #1;
    checks++; if (io1 !== 1'b0 || romcode_EN_A !== 1'b0) begin
      errors++; $display("FAIL rst_data_async got io1=%b en=%b exp 0/0", io1, romcode_EN_A);
    end
    csb = 1'b1;
    spiclk = 1'b0;
    wait_cyc(3);
    ap_rst = 1'b0;
    wait_cyc(4);
    spi_begin();
    send_read(24'h000000);
    spi_byte(8'h00, rx);
    spi_end();
    checks++; if (rx !== 8'h11) begin errors++; $display("FAIL rst_data_recover got %h exp 11", rx); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read_word0();
    test_read_offset2();
    test_bad_opcode();
    test_abort();
    test_wrap();
    test_reset_in_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
